// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pkg
// Description : Shared definitions for the async FIFO read-domain arbiter.
//               State encoding for the arbiter FSM, default requester and
//               burst sizing, and the FIFO geometry that the read-side logic
//               is built around (8 entries, 4-bit Gray/binary pointers).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_arb_state_e;

  localparam int FIFO_RD_NUM_REQ   = 4;
  localparam int FIFO_RD_MAX_BURST = 4;
  localparam int FIFO_DEPTH        = 8;
  // One extra pointer bit beyond log2(depth) distinguishes full from empty.
  localparam int FIFO_PTR_W        = 4;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Searches req upward from
//               last+1, wrapping modulo NUM_REQ, and returns the first set
//               bit as a one-hot vector and as an encoded index. When req is
//               all zero, pick is zero and idx is zero.
// Ports       : req  [NUM_REQ-1:0] in  - request vector
//               last [ID_W-1:0]    in  - index granted most recently
//               pick [NUM_REQ-1:0] out - one-hot winner
//               idx  [ID_W-1:0]    out - encoded winner
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    logic            w_found;
    logic [ID_W-1:0] w_cand;
    pick    = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    // Offsets 1..NUM_REQ: offset NUM_REQ lands back on last itself, so a lone
    // requester is re-granted once everyone else has been considered.
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = ID_W'((int'(last) + i) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        pick[w_cand] = 1'b1;
        idx          = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter
// Description : Shares the read port of the 8-deep async FIFO among NUM_REQ
//               requesters. Round-robin grants of bounded bursts (up to
//               MAX_BURST reads); the read enable is never asserted while the
//               FIFO is empty. A registered valid strobe tagged with the
//               owning requester follows each read by one cycle.
// Ports       : rd_clk      in  - read-domain clock
//               reset       in  - synchronous, active-high
//               req         in  - per-requester level request
//               f_empty     in  - FIFO empty flag
//               gnt         out - one-hot registered grant
//               rd_en       out - FIFO read enable
//               rd_valid    out - read data valid (rd_en delayed one cycle)
//               rd_valid_id out - requester owning the rd_valid beat
//               busy        out - burst in progress
//               rd_count    out - (FIFO_RD_ARB_STATS_EN) wrapping read count
//               starve      out - (FIFO_RD_ARB_STATS_EN) per-requester flag
// Options     : define FIFO_RD_ARB_STATS_EN to add rd_count / starve.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NUM_REQ   = FIFO_RD_NUM_REQ,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = FIFO_RD_MAX_BURST
) (
  input  logic               rd_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               f_empty,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rd_en,
  output logic               rd_valid,
  output logic [ID_W-1:0]    rd_valid_id,
  output logic               busy
`ifdef FIFO_RD_ARB_STATS_EN
  ,
  output logic [15:0]        rd_count,
  output logic [NUM_REQ-1:0] starve
`endif
);

  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST);

  rd_arb_state_e      state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rd_valid_q;
  logic [ID_W-1:0]    rd_valid_id_q;

  logic [NUM_REQ-1:0] pick;
  logic [ID_W-1:0]    pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    count_d = count_q;
    // gnt_q is zero outside BURST, so the owner check alone suffices there;
    // the state term keeps intent explicit.
    rd_en   = (state_q == BURST) && (|(gnt_q & req)) && !f_empty;
    case (state_q)
      IDLE: begin
        if ((|req) && !f_empty) begin
          state_d = BURST;
          gnt_d   = pick;
          last_d  = pick_idx;
          count_d = '0;
        end
      end
      BURST: begin
        if (rd_en) begin
          count_d = count_q + CNT_W'(1);
        end
        // A cycle without a read means the owner dropped req or the FIFO ran
        // dry; either way the burst is over. Dropping to gnt=0 for a cycle
        // guarantees an IDLE gap between owners.
        if (!rd_en || (count_d == CNT_LIMIT)) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      last_q        <= ID_W'(NUM_REQ - 1);
      count_q       <= '0;
      rd_valid_q    <= 1'b0;
      rd_valid_id_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      count_q    <= count_d;
      rd_valid_q <= rd_en;
      // During a burst last_q is the encoded grant.
      if (rd_en) begin
        rd_valid_id_q <= last_q;
      end
    end
  end

  assign gnt         = gnt_q;
  assign rd_valid    = rd_valid_q;
  assign rd_valid_id = rd_valid_id_q;
  assign busy        = (state_q == BURST);

`ifdef FIFO_RD_ARB_STATS_EN
  localparam int STARVE_LIM = 4 * MAX_BURST;
  localparam int WAIT_W     = $clog2(STARVE_LIM + 1);

  logic [15:0] rd_count_q;

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      rd_count_q <= '0;
    end else if (rd_en) begin
      rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign rd_count = rd_count_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_starve
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              starve_q;

    // Counts consecutive cycles of unserved request, saturating at the limit.
    always_comb begin
      wait_cnt_d = '0;
      if (req[g] && !gnt_q[g]) begin
        wait_cnt_d = (wait_cnt_q == WAIT_W'(STARVE_LIM)) ? wait_cnt_q
                                                          : wait_cnt_q + WAIT_W'(1);
      end
    end

    always_ff @(posedge rd_clk) begin
      if (reset) begin
        wait_cnt_q <= '0;
        starve_q   <= 1'b0;
      end else begin
        wait_cnt_q <= wait_cnt_d;
        starve_q   <= gnt_q[g] ? 1'b0
                               : (starve_q | (wait_cnt_d == WAIT_W'(STARVE_LIM)));
      end
    end

    assign starve[g] = starve_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_arbiter
// Description : Self-checking bench for fifo_rd_arbiter. A behavioural model
//               (owner / reads-so-far / last-winner bookkeeping) predicts the
//               outputs every cycle; directed phases follow the test plan and
//               a randomized phase exercises arbitrary req / f_empty / reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int MAX_BURST = 4;

  logic               clk;
  logic               reset;
  logic [NUM_REQ-1:0] req;
  logic               f_empty;
  logic [NUM_REQ-1:0] gnt;
  logic               rd_en;
  logic               rd_valid;
  logic [ID_W-1:0]    rd_valid_id;
  logic               busy;
`ifdef FIFO_RD_ARB_STATS_EN
  logic [15:0]        rd_count;
  logic [NUM_REQ-1:0] starve;
`endif

  fifo_rd_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ID_W      (ID_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .rd_clk      (clk),
    .reset       (reset),
    .req         (req),
    .f_empty     (f_empty),
    .gnt         (gnt),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_valid_id (rd_valid_id),
    .busy        (busy)
`ifdef FIFO_RD_ARB_STATS_EN
    ,
    .rd_count    (rd_count),
    .starve      (starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: owner = -1 when no burst is in progress.
  int m_owner = -1;
  int m_reads = 0;
  int m_last  = NUM_REQ - 1;
  bit m_vld   = 1'b0;
  int m_vid   = 0;
  int m_total = 0;
  int m_wait[NUM_REQ];
  bit m_starve[NUM_REQ];

  // Observations used by the directed checks.
  int obs_reads = 0;
  int obs_grants[$];
  logic [NUM_REQ-1:0] prev_gnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [NUM_REQ-1:0] r, input logic fe, input logic rs, input bit chk_en);
    logic [NUM_REQ-1:0] e_gnt;
    logic               e_rden;
    logic [NUM_REQ-1:0] e_starve;
    req     = r;
    f_empty = fe;
    reset   = rs;
    @(negedge clk);
    e_gnt  = '0;
    e_rden = 1'b0;
    if (m_owner >= 0) begin
      e_gnt  = 4'b0001 << m_owner[ID_W-1:0];
      e_rden = r[m_owner[ID_W-1:0]] && !fe;
    end
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rd_en", 32'(rd_en), 32'(e_rden));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("rd_valid", 32'(rd_valid), 32'(m_vld));
      if (m_vld) chk("rd_valid_id", 32'(rd_valid_id), 32'(m_vid));
`ifdef FIFO_RD_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++) e_starve[i] = m_starve[i];
      chk("rd_count", 32'(rd_count), 32'(m_total));
      chk("starve", 32'(starve), 32'(e_starve));
`endif
      if (rd_en === 1'b1) obs_reads++;
      if ((gnt !== '0) && (prev_gnt === '0)) begin
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i] === 1'b1) obs_grants.push_back(i);
      end
      prev_gnt = gnt;
    end
    e_starve = '0;
    @(posedge clk);
    if (rs) begin
      m_owner = -1; m_reads = 0; m_last = NUM_REQ - 1;
      m_vld = 1'b0; m_vid = 0; m_total = 0;
      for (int i = 0; i < NUM_REQ; i++) begin m_wait[i] = 0; m_starve[i] = 1'b0; end
    end else begin
      m_vld = e_rden;
      if (e_rden) begin
        m_vid   = m_owner;
        m_total = (m_total + 1) % 65536;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        m_wait[i] = (r[i] && (m_owner != i)) ? m_wait[i] + 1 : 0;
        if (m_owner == i) m_starve[i] = 1'b0;
        else if (m_wait[i] >= 4 * MAX_BURST) m_starve[i] = 1'b1;
      end
      if (m_owner < 0) begin
        if ((r != '0) && !fe) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_last + k) % NUM_REQ;
            if (m_owner < 0 && r[c[ID_W-1:0]]) m_owner = c;
          end
          m_last  = m_owner;
          m_reads = 0;
        end
      end else if (e_rden) begin
        m_reads++;
        if (m_reads == MAX_BURST) m_owner = -1;
      end else begin
        m_owner = -1;
      end
    end
    #1;
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [NUM_REQ-1:0] rr;
    logic               rfe;
    req = '0; f_empty = 1'b1; reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin m_wait[i] = 0; m_starve[i] = 1'b0; end
    #1;

    // Reset state.
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // Single requester: exactly MAX_BURST reads then an IDLE cycle.
    obs_reads = 0;
    for (int i = 0; i < 6; i++) step(4'b0001, 1'b0, 1'b0, 1'b1);
    chk("single_burst_reads", 32'(obs_reads), 32'(MAX_BURST));
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // All requesting from fresh reset: grant order 0,1,2,3,0.
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    obs_grants.delete();
    for (int i = 0; i < 26; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);
    chk("rr_grant_count", 32'(obs_grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < obs_grants.size()) chk("rr_order", 32'(obs_grants[i]), 32'(exp_order[i]));
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // FIFO goes empty after 2 reads; no grant while empty.
    obs_reads = 0;
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b1, 1'b0, 1'b1);
    chk("empty_reads", 32'(obs_reads), 32'd2);
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // Requester 2 drops after one read; then 0 and 3 pending -> 3 wins.
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    obs_grants.delete();
    for (int i = 0; i < 4; i++) step(4'b1001, 1'b0, 1'b0, 1'b1);
    chk("after_drop_first", 32'(obs_grants.size() > 0 ? obs_grants[0] : -1), 32'd3);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // Reset during the 3rd read of a burst; next grant goes to 0.
    step(4'b0110, 1'b0, 1'b0, 1'b1);
    step(4'b0110, 1'b0, 1'b0, 1'b1);
    step(4'b0110, 1'b0, 1'b0, 1'b1);
    step(4'b0110, 1'b0, 1'b1, 1'b1);
    obs_grants.delete();
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b0, 1'b0, 1'b1);
    chk("post_reset_grant", 32'(obs_grants.size() > 0 ? obs_grants[0] : -1), 32'd0);

    // Requester 3 blocked by an empty FIFO long enough to starve, then served.
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(4'b1000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b1000, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    rr = '0; rfe = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rr = NUM_REQ'($urandom_range(0, 15));
      rfe = ($urandom_range(0, 5) == 0);
      step(rr, rfe, ($urandom_range(0, 99) == 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
